// File: rtl/mem_ctrl_arb_if.sv
// Request, completion and byte-RAM signals between IF/MEM stages, the controller and the RAM.
interface mem_ctrl_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [WORD_W-1:0] if_data;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_done;
  logic [WORD_W-1:0] mem_rdata;
  logic              busy_o;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, busy_o, ram_addr, ram_wr, ram_dout
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, busy_o, ram_addr, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Arbitrates IF and MEM requests onto a byte-wide synchronous RAM, one transaction at a time,
// serialising words into little-endian byte beats.
module mem_ctrl_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_ctrl_arb_if.slave  bus
);
  localparam int unsigned BYTES  = WORD_W / 8;
  localparam int unsigned BIDX_W = $clog2(BYTES);
  localparam int unsigned CNT_W  = BIDX_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              owner_mem_q, owner_mem_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [7:0]        dout_q, dout_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [WORD_W-1:0] if_data_q, if_data_d;
  logic [WORD_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              busy_q, busy_d;
  logic [BIDX_W-1:0] cap_idx, wr_idx;

  // Read data lags the address by one cycle, so cycle t captures byte t-1.
  assign cap_idx = BIDX_W'(cyc_q - CNT_W'(1));
  assign wr_idx  = BIDX_W'(cyc_q + CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_mem_q <= 1'b0;
      n_q         <= '0;
      cyc_q       <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      dout_q      <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      n_q         <= n_d;
      cyc_q       <= cyc_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      dout_q      <= dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    n_d         = n_q;
    cyc_d       = cyc_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    addr_d      = addr_q;
    wr_d        = 1'b0;
    dout_d      = dout_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        // MEM wins ties; a held if_req is picked up on a later IDLE cycle.
        if (bus.mem_req) begin
          owner_mem_d = 1'b1;
          case (bus.mem_len)
            2'd0:    n_d = CNT_W'(1);
            2'd1:    n_d = CNT_W'(2);
            default: n_d = CNT_W'(BYTES);
          endcase
          wdata_d = bus.mem_wdata;
          addr_d  = bus.mem_addr;
          cyc_d   = '0;
          rbuf_d  = '0;
          if (bus.mem_we) begin
            state_d = WRITE;
            wr_d    = 1'b1;
            dout_d  = bus.mem_wdata[7:0];
          end else begin
            state_d = READ;
          end
        end else if (bus.if_req) begin
          owner_mem_d = 1'b0;
          n_d         = CNT_W'(BYTES);
          addr_d      = bus.if_addr;
          cyc_d       = '0;
          rbuf_d      = '0;
          state_d     = READ;
        end
      end

      READ: begin
        cyc_d = cyc_q + CNT_W'(1);
        if (cyc_q + CNT_W'(1) < n_q) addr_d = addr_q + ADDR_W'(1);
        if (cyc_q != '0) rbuf_d[{cap_idx, 3'b000} +: 8] = bus.ram_din;
        if (cyc_q == n_q) begin
          state_d = DONE;
          if (owner_mem_q) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = rbuf_d;
          end else begin
            if_done_d = 1'b1;
            if_data_d = rbuf_d;
          end
        end
      end

      WRITE: begin
        if (cyc_q == n_q - CNT_W'(1)) begin
          state_d    = DONE;
          mem_done_d = 1'b1;
        end else begin
          wr_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
          cyc_d  = cyc_q + CNT_W'(1);
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.busy_o    = busy_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wr    = wr_q;
  assign bus.ram_dout  = dout_q;
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Directed bench for mem_ctrl_arb: vector table of transactions plus multi-cycle corner sequences.
module tb_mem_ctrl_arb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_arb_if #(.ADDR_W(32), .WORD_W(32)) bus ();
  mem_ctrl_arb #(.ADDR_W(32), .WORD_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Byte RAM model, 1 KiB aliased; read data valid the cycle after the address.
  logic [7:0] ram [1024];
  logic       pl_clr, pl_en;
  logic [9:0] pl_a;
  logic [7:0] pl_d;
  always @(posedge clk) begin
    bus.ram_din <= ram[bus.ram_addr[9:0]];
    if (pl_clr) for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    else if (pl_en) ram[pl_a] <= pl_d;
    else if (bus.ram_wr) ram[bus.ram_addr[9:0]] <= bus.ram_dout;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] t_addr [32];
  logic        t_wr   [32];
  logic [7:0]  t_dout [32];
  logic        t_busy [32];

  typedef struct {
    logic        is_if;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        chk;
    logic [31:0] data;
  } vec_t;
  localparam int NV = 11;
  vec_t v [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Issue one request, trace cycles C1.., return done latency (0 = timeout) and data.
  task automatic run_txn(input logic is_if, input logic we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] data);
    logic stray;
    lat = 0; data = '0; stray = 1'b0;
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_len = len;
      bus.mem_addr = addr; bus.mem_wdata = wdata;
    end
    t_busy[0] = bus.busy_o;
    for (int k = 1; k < 24 && lat == 0; k++) begin
      tick();
      t_addr[k] = bus.ram_addr; t_wr[k] = bus.ram_wr;
      t_dout[k] = bus.ram_dout; t_busy[k] = bus.busy_o;
      if (is_if ? bus.mem_done : bus.if_done) stray = 1'b1;
      if (is_if ? bus.if_done : bus.mem_done) begin
        lat  = k;
        data = is_if ? bus.if_data : bus.mem_rdata;
      end
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    tick();
    check("stray done", 32'(stray), 32'h0);
    check("busy after done", 32'(bus.busy_o), 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, md, idn, cnt, d1, d2;
    logic [31:0] data, rd, id;
    logic b7;

    rst = 1'b1; pl_clr = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    bus.mem_len = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
    tick();
    pl_clr = 1'b0;
    preload(10'h100, 8'h13); preload(10'h101, 8'h05);
    preload(10'h102, 8'h10); preload(10'h103, 8'h00);
    preload(10'h3FE, 8'h11); preload(10'h3FF, 8'h22);
    preload(10'h000, 8'h33); preload(10'h001, 8'h44);

    check("reset ctl", {27'd0, bus.if_done, bus.mem_done, bus.busy_o, bus.ram_wr, 1'b0}, 32'h0);
    check("reset ram_addr", bus.ram_addr, 32'h0);
    check("reset ram_dout", 32'(bus.ram_dout), 32'h0);
    check("reset data", bus.if_data | bus.mem_rdata, 32'h0);
    rst = 1'b0;
    tick();

    //          is_if we   len    addr          wdata          lat chk  data
    v[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         6, 1'b1, 32'h0010_0513};
    v[1]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0020, 32'hDEAD_BEEF, 5, 1'b0, 32'h0};
    v[2]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0020, 32'h0,         6, 1'b1, 32'hDEAD_BEEF};
    v[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0022, 32'h0,         4, 1'b1, 32'h0000_DEAD};
    v[4]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0021, 32'h0,         3, 1'b1, 32'h0000_00BE};
    v[5]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0040, 32'h1234_5678, 3, 1'b0, 32'h0};
    v[6]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'h0,         6, 1'b1, 32'h0000_5678};
    v[7]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0043, 32'hAABB_CCDD, 2, 1'b0, 32'h0};
    v[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'h0,         6, 1'b1, 32'hDD00_5678};
    v[9]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0020, 32'h0,         6, 1'b1, 32'hDEAD_BEEF};
    v[10] = '{1'b1, 1'b0, 2'd0, 32'h0000_0020, 32'h0,         6, 1'b1, 32'hDEAD_BEEF};

    for (int i = 0; i < NV; i++) begin
      run_txn(v[i].is_if, v[i].we, v[i].len, v[i].addr, v[i].wdata, lat, data);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(v[i].lat));
      if (v[i].chk) check($sformatf("vec%0d data", i), data, v[i].data);
    end

    // Fetch trace: address beats, held last address, busy profile.
    run_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'h0, lat, data);
    check("fetch addr C1", t_addr[1], 32'h100);
    check("fetch addr C4", t_addr[4], 32'h103);
    check("fetch addr held C5", t_addr[5], 32'h103);
    check("fetch busy C0..C6", {25'd0, t_busy[0], t_busy[1], t_busy[2], t_busy[3],
                                t_busy[4], t_busy[5], t_busy[6]}, 32'h3F);
    check("fetch ram_wr", {28'd0, t_wr[1], t_wr[2], t_wr[3], t_wr[4]}, 32'h0);

    // Store trace: byte order and strobe window.
    run_txn(1'b0, 1'b1, 2'd2, 32'h80, 32'hDEADBEEF, lat, data);
    check("store bytes", {t_dout[1], t_dout[2], t_dout[3], t_dout[4]}, 32'hEFBEADDE);
    check("store wr C1..C5", {27'd0, t_wr[1], t_wr[2], t_wr[3], t_wr[4], t_wr[5]}, 32'h1E);
    check("store addr C4", t_addr[4], 32'h83);

    // Simultaneous requests: load served first, fetch follows.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd0; bus.mem_addr = 32'h21;
    md = 0; idn = 0; rd = '0; id = '0;
    for (int k = 1; k < 30 && idn == 0; k++) begin
      tick();
      if (bus.mem_done) begin md = k; rd = bus.mem_rdata; bus.mem_req = 1'b0; end
      if (bus.if_done)  begin idn = k; id = bus.if_data; bus.if_req = 1'b0; end
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    tick();
    check("arb mem_done cycle", 32'(md), 32'd3);
    check("arb rdata", rd, 32'h0000_00BE);
    check("arb if_done cycle", 32'(idn), 32'd10);
    check("arb if_data", id, 32'h0010_0513);

    // Address wrap across 0xFFFFFFFF.
    run_txn(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, lat, data);
    check("wrap addr C2", t_addr[2], 32'hFFFF_FFFF);
    check("wrap addr C3", t_addr[3], 32'h0000_0000);
    check("wrap addr C4", t_addr[4], 32'h0000_0001);
    check("wrap data", data, 32'h4433_2211);

    // Reset during C3 of a word store.
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd2;
    bus.mem_addr = 32'h60; bus.mem_wdata = 32'h0102_0304;
    tick(); tick(); tick();
    rst = 1'b1; bus.mem_req = 1'b0;
    tick();
    check("rst ram_wr/done/busy", {29'd0, bus.ram_wr, bus.mem_done, bus.busy_o}, 32'h0);
    check("rst data cleared", bus.mem_rdata | bus.if_data, 32'h0);
    rst = 1'b0;
    check("rst partial bytes", {ram[10'h60], ram[10'h61], ram[10'h62], ram[10'h63]}, 32'h0403_0200);
    md = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.mem_done || bus.ram_wr) md = 1;
    end
    check("rst no late activity", 32'(md), 32'h0);
    run_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'h0, lat, data);
    check("post-rst fetch latency", 32'(lat), 32'd6);
    check("post-rst fetch data", data, 32'h0010_0513);

    // Back-to-back fetches with if_req held one cycle past if_done.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    cnt = 0; d1 = 0; d2 = 0; b7 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 8) bus.if_req = 1'b0;
      if (k == 7) b7 = bus.busy_o;
      if (bus.if_done) begin
        cnt++;
        if (d1 == 0) d1 = k; else d2 = k;
      end
    end
    check("b2b done count", 32'(cnt), 32'd2);
    check("b2b first done", 32'(d1), 32'd6);
    check("b2b second done", 32'(d2), 32'd13);
    check("b2b idle gap busy", 32'(b7), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
